// File: rtl/pcileech_ft601_rxdemux.sv
// pcileech_ft601_rxdemux: pairs FT601 RX words into qwords, checks the magic
// byte and routes each qword into a TLP or CFG show-ahead buffer.
// Optional statistics counter: define PCILEECH_RXDEMUX_STATS_EN.
module pcileech_ft601_rxdemux #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        FT601_CLK,
  input  logic        FT601_RESET_N,
  input  logic [31:0] rx_data,
  input  logic        rx_wren,
  output logic [63:0] tlp_data,
  output logic        tlp_valid,
  input  logic        tlp_ready,
  output logic [63:0] cfg_data,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic        err_sync,
  output logic        err_ovf,
  output logic [15:0] stat_drop_cnt
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned TW    = 16;
  localparam logic [7:0]  MAGIC = 8'h77;

  typedef enum logic {W0, W1} state_t;

  state_t          state, state_n;
  logic [31:0]     hold;
  logic            hold_ld;
  logic [TW-1:0]   tmo_cnt, tmo_n;
  logic            commit;
  logic            commit_ch;
  logic            sync_err;
  logic            drop;
  logic [63:0]     din;

  logic [PW-1:0]   wr_ptr [2];
  logic [PW-1:0]   rd_ptr [2];
  logic [PW-1:0]   wr_n   [2];
  logic [PW-1:0]   rd_n   [2];
  logic [63:0]     mem    [2][DEPTH];
  logic [63:0]     dat_q  [2];
  logic [63:0]     head_n [2];
  logic [1:0]      vld_q;
  logic [1:0]      vld_n;
  logic [1:0]      full;
  logic [1:0]      rdy;
  logic [1:0]      pop;
  logic [1:0]      push;

  assign din = {rx_data, hold};
  assign rdy = {cfg_ready, tlp_ready};

  // State, hold word and idle counter registers
  always_ff @(posedge FT601_CLK or negedge FT601_RESET_N) begin
    if (!FT601_RESET_N) begin
      state   <= W0;
      hold    <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      tmo_cnt <= tmo_n;
      if (hold_ld) hold <= rx_data;
    end
  end

  // Word pairing, magic check, slip and idle timeout decisions
  always_comb begin
    state_n   = state;
    hold_ld   = 1'b0;
    commit    = 1'b0;
    commit_ch = 1'b0;
    sync_err  = 1'b0;
    tmo_n     = tmo_cnt;
    if (rx_wren)
      tmo_n = '0;
    else if (state == W1 && tmo_cnt != TW'(TIMEOUT))
      tmo_n = tmo_cnt + 1'b1;
    case (state)
      W0: begin
        if (rx_wren) begin
          hold_ld = 1'b1;
          state_n = W1;
        end
      end
      W1: begin
        if (rx_wren) begin
          if (rx_data[31:24] == MAGIC) begin
            state_n = W0;
            // type 1x is dropped silently
            if (!rx_data[17]) begin
              commit    = 1'b1;
              commit_ch = rx_data[16];
            end
          end else begin
            // slip by one word: this word may be the real word0
            sync_err = 1'b1;
            hold_ld  = 1'b1;
          end
        end else if (tmo_n == TW'(TIMEOUT)) begin
          sync_err = 1'b1;
          state_n  = W0;
        end
      end
      default: state_n = W0;
    endcase
  end

  // Buffer push/pop qualification and next-state of pointers and head word
  always_comb begin
    drop = 1'b0;
    for (int c = 0; c < 2; c++) begin
      full[c] = (wr_ptr[c][FIFO_AW] != rd_ptr[c][FIFO_AW]) &&
                (wr_ptr[c][FIFO_AW-1:0] == rd_ptr[c][FIFO_AW-1:0]);
      pop[c]  = vld_q[c] && rdy[c];
      push[c] = commit && (commit_ch == c[0]) && (!full[c] || pop[c]);
      if (commit && (commit_ch == c[0]) && full[c] && !pop[c]) drop = 1'b1;
      wr_n[c]   = wr_ptr[c] + PW'(push[c]);
      rd_n[c]   = rd_ptr[c] + PW'(pop[c]);
      vld_n[c]  = (wr_n[c] != rd_n[c]);
      head_n[c] = (push[c] && (wr_ptr[c] == rd_n[c])) ? din
                                                      : mem[c][rd_n[c][FIFO_AW-1:0]];
    end
  end

  // Buffer storage (no reset needed; contents are qualified by the pointers)
  always_ff @(posedge FT601_CLK) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem[c][wr_ptr[c][FIFO_AW-1:0]] <= din;
    end
  end

  // Buffer pointers and registered show-ahead outputs
  always_ff @(posedge FT601_CLK or negedge FT601_RESET_N) begin
    if (!FT601_RESET_N) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        dat_q[c]  <= '0;
      end
      vld_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= wr_n[c];
        rd_ptr[c] <= rd_n[c];
        dat_q[c]  <= vld_n[c] ? head_n[c] : '0;
      end
      vld_q <= vld_n;
    end
  end

  // Error pulses
  always_ff @(posedge FT601_CLK or negedge FT601_RESET_N) begin
    if (!FT601_RESET_N) begin
      err_sync <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      err_sync <= sync_err;
      err_ovf  <= drop;
    end
  end

  assign tlp_data  = dat_q[0];
  assign tlp_valid = vld_q[0];
  assign cfg_data  = dat_q[1];
  assign cfg_valid = vld_q[1];

`ifdef PCILEECH_RXDEMUX_STATS_EN
  logic [15:0] stat_q;
  logic [16:0] stat_sum;

  assign stat_sum = 17'(stat_q) + 17'(sync_err) + 17'(drop);

  // Saturating count of overflow drops and sync errors
  always_ff @(posedge FT601_CLK or negedge FT601_RESET_N) begin
    if (!FT601_RESET_N) stat_q <= '0;
    else                stat_q <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
  end

  assign stat_drop_cnt = stat_q;
`else
  assign stat_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pcileech_ft601_rxdemux.sv
// Bench for pcileech_ft601_rxdemux: directed scenarios plus random traffic,
// checked against a queue-based model of the qword framing rules.
module tb_pcileech_ft601_rxdemux;

  localparam int unsigned AW  = 4;
  localparam int unsigned TMO = 8;
  localparam int          CAP = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_wren = 1'b0;
  logic [63:0] tlp_data, cfg_data;
  logic        tlp_valid, cfg_valid;
  logic        tlp_ready = 1'b0, cfg_ready = 1'b0;
  logic        err_sync, err_ovf;
  logic [15:0] stat_drop_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [63:0] tq[$];
  logic [63:0] cq[$];
  bit          have = 0;
  logic [31:0] hold = '0;
  int          idle = 0;
  int          stat = 0;
  bit          es = 0, eo = 0;

  pcileech_ft601_rxdemux #(.FIFO_AW(AW), .TIMEOUT(TMO)) dut (
    .FT601_CLK(clk), .FT601_RESET_N(rst_n),
    .rx_data(rx_data), .rx_wren(rx_wren),
    .tlp_data(tlp_data), .tlp_valid(tlp_valid), .tlp_ready(tlp_ready),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .err_sync(err_sync), .err_ovf(err_ovf), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] head(input logic [63:0] q[$]);
    return (q.size() != 0) ? q[0] : 64'h0;
  endfunction

  task automatic check_all();
    chk("tlp_valid", 64'(tlp_valid), 64'(tq.size() != 0));
    chk("tlp_data",  tlp_data, head(tq));
    chk("cfg_valid", 64'(cfg_valid), 64'(cq.size() != 0));
    chk("cfg_data",  cfg_data, head(cq));
    chk("err_sync",  64'(err_sync), 64'(es));
    chk("err_ovf",   64'(err_ovf), 64'(eo));
`ifdef PCILEECH_RXDEMUX_STATS_EN
    chk("stat", 64'(stat_drop_cnt), 64'(stat));
`else
    chk("stat", 64'(stat_drop_cnt), 64'h0);
`endif
  endtask

  // One clock: apply inputs, advance the model, check after the edge
  task automatic cycle(input logic wren, input logic [31:0] d, input logic tr, input logic cr);
    rx_wren = wren; rx_data = d; tlp_ready = tr; cfg_ready = cr;
    es = 0; eo = 0;
    if (tr && tq.size() != 0) void'(tq.pop_front());
    if (cr && cq.size() != 0) void'(cq.pop_front());
    if (wren) begin
      idle = 0;
      if (!have) begin
        hold = d; have = 1;
      end else if (d[31:24] == 8'h77) begin
        have = 0;
        if (d[17:16] == 2'b00) begin
          if (tq.size() < CAP) tq.push_back({d, hold}); else eo = 1;
        end else if (d[17:16] == 2'b01) begin
          if (cq.size() < CAP) cq.push_back({d, hold}); else eo = 1;
        end
      end else begin
        es = 1; hold = d;
      end
    end else if (have) begin
      idle++;
      if (idle >= TMO) begin es = 1; have = 0; end
    end
    stat = stat + int'(es) + int'(eo);
    if (stat > 65535) stat = 65535;
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    rx_wren = 1'b0;
    rst_n = 1'b0;
    #1;
    tq.delete(); cq.delete();
    have = 0; idle = 0; stat = 0; es = 0; eo = 0;
    chk("rst_tlp_valid", 64'(tlp_valid), 64'h0);
    chk("rst_tlp_data",  tlp_data, 64'h0);
    chk("rst_cfg_valid", 64'(cfg_valid), 64'h0);
    chk("rst_cfg_data",  cfg_data, 64'h0);
    chk("rst_errs",      64'({err_sync, err_ovf}), 64'h0);
    chk("rst_stat",      64'(stat_drop_cnt), 64'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    int          tb, cb;

    // reset state
    #2;
    do_reset();

    // T1: TLP qword
    cycle(1, 32'h11223344, 0, 0);
    cycle(1, 32'h77000000, 0, 0);
    chk("t1_tlp_valid", 64'(tlp_valid), 64'h1);
    chk("t1_tlp_data",  tlp_data, 64'h77000000_11223344);
    chk("t1_cfg_valid", 64'(cfg_valid), 64'h0);
    cycle(0, 0, 1, 0);

    // T2: CFG qword then pop
    cycle(1, 32'hA5A5A5A5, 0, 0);
    cycle(1, 32'h77010000, 0, 0);
    chk("t2_cfg_data", cfg_data, 64'h77010000_A5A5A5A5);
    cycle(0, 0, 0, 1);
    chk("t2_cfg_pop", 64'(cfg_valid), 64'h0);

    // T3: bad magic slips by one word
    cycle(1, 32'h1, 0, 0);
    cycle(1, 32'h2, 0, 0);
    chk("t3_err_sync", 64'(err_sync), 64'h1);
    cycle(1, 32'h77000000, 0, 0);
    chk("t3_err_once", 64'(err_sync), 64'h0);
    chk("t3_tlp_data", tlp_data, 64'h77000000_00000002);

    // T4: overflow of the TLP buffer, then full drain
    do_reset();
    for (int i = 0; i < CAP + 1; i++) begin
      cycle(1, 32'(i), 0, 0);
      cycle(1, 32'h77000000, 0, 0);
    end
    chk("t4_err_ovf", 64'(err_ovf), 64'h1);
`ifdef PCILEECH_RXDEMUX_STATS_EN
    chk("t4_stat", 64'(stat_drop_cnt), 64'h1);
`else
    chk("t4_stat", 64'(stat_drop_cnt), 64'h0);
`endif
    for (int i = 0; i < CAP; i++) begin
      chk("t4_drain", tlp_data, {32'h77000000, 32'(i)});
      cycle(0, 0, 1, 0);
    end
    chk("t4_empty", 64'(tlp_valid), 64'h0);

    // T5: half-qword timeout
    cycle(1, 32'h9, 0, 0);
    for (int i = 0; i < int'(TMO); i++) cycle(0, 0, 0, 0);
    chk("t5_err_sync", 64'(err_sync), 64'h1);
    cycle(1, 32'h5, 0, 0);
    cycle(1, 32'h77000000, 0, 0);
    chk("t5_tlp_data", tlp_data, 64'h77000000_00000005);
    cycle(0, 0, 1, 0);

    // T6: reset while in W1 with 3 qwords buffered
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h100 + 32'(i), 0, 0);
      cycle(1, 32'h77000000, 0, 0);
    end
    cycle(1, 32'hDEAD0000, 0, 0);
    do_reset();
    cycle(1, 32'hCAFE0001, 0, 0);
    cycle(1, 32'h77000000, 0, 0);
    chk("t6_tlp_data", tlp_data, 64'h77000000_CAFE0001);
    cycle(0, 0, 1, 0);
    chk("t6_single", 64'(tlp_valid), 64'h0);

    // random traffic with varying consumer pressure
    tb = 5; cb = 5;
    for (int n = 0; n < 2000; n++) begin
      if (n % 200 == 0) begin
        tb = $urandom_range(0, 10);
        cb = $urandom_range(0, 10);
      end
      if ($urandom_range(0, 59) == 0) begin
        for (int k = 0; k < int'(TMO) + 1; k++)
          cycle(0, 0, 1'($urandom_range(0, 9) < tb), 1'($urandom_range(0, 9) < cb));
      end else begin
        w = $urandom();
        if ($urandom_range(0, 9) < 7) begin
          w[31:24] = 8'h77;
          case ($urandom_range(0, 5))
            0, 1, 2: w[17:16] = 2'b00;
            3, 4:    w[17:16] = 2'b01;
            default: w[17:16] = 2'(2 + $urandom_range(0, 1));
          endcase
        end
        cycle(1'($urandom_range(0, 9) < 7), w,
              1'($urandom_range(0, 9) < tb), 1'($urandom_range(0, 9) < cb));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
